// File: rtl/fifo_flex_pkg.sv
// rtl/fifo_flex_pkg.sv - shared sizing helpers and parameter limits for sync_fifo_flex
package fifo_flex_pkg;

   localparam int MIN_DATA_W = 1;
   localparam int MIN_DEPTH  = 2;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Occupancy must be able to hold DEPTH itself, hence depth+1.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// rtl/sync_fifo_flex_if.sv - producer/consumer bus of sync_fifo_flex
interface sync_fifo_flex_if
   import fifo_flex_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) ();

   localparam int CW = cnt_w(DEPTH);

   logic              w_en;
   logic [DATA_W-1:0] wdata;
   logic              r_en;
   logic [DATA_W-1:0] rdata;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              underflow;

   modport master (
      output w_en, wdata, r_en,
      input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  w_en, wdata, r_en,
      output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/fifo_flex_mem.sv
// rtl/fifo_flex_mem.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
module fifo_flex_mem
   import fifo_flex_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int PW     = ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [PW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [PW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with occupancy, thresholds, error pulses, optional FWFT
module sync_fifo_flex
   import fifo_flex_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic            clk,
   input  logic            rst,
   sync_fifo_flex_if.slave bus
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   if (DATA_W < MIN_DATA_W) begin : g_bad_width
      $error("sync_fifo_flex: DATA_W must be >= 1");
   end
   if (DEPTH < MIN_DEPTH) begin : g_bad_depth
      $error("sync_fifo_flex: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_flex: AF_THRESH out of range 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flex: AE_THRESH out of range 0..DEPTH-1");
   end

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d, underflow_q, underflow_d;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] head;

   // DEPTH need not be a power of two, so wrap on an explicit compare.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      rd_acc      = bus.r_en && (count_q != '0);
      wr_acc      = bus.w_en && ((count_q != CW'(DEPTH)) || rd_acc);
      wr_ptr_d    = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d    = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
      overflow_d  = bus.w_en && !wr_acc;
      underflow_d = bus.r_en && !rd_acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_flex_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PW     (PW)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc && !rst),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.wdata),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   if (FWFT != 0) begin : g_fwft
      assign bus.rdata = (count_q == '0) ? '0 : head;
   end else begin : g_std
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            rdata_q <= '0;
         end else if (rd_acc) begin
            rdata_q <= head;
         end
      end
      assign bus.rdata = rdata_q;
   end

   assign bus.count        = count_q;
   assign bus.full         = (count_q == CW'(DEPTH));
   assign bus.empty        = (count_q == '0);
   assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
   assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - directed bench for sync_fifo_flex, standard and FWFT builds
module tb_sync_fifo_flex;
   import fifo_flex_pkg::*;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   sync_fifo_flex_if #(.DATA_W(8), .DEPTH(16)) a_if ();
   sync_fifo_flex_if #(.DATA_W(8), .DEPTH(5))  b_if ();

   sync_fifo_flex #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_a (
      .clk (clk), .rst (rst_a), .bus (a_if)
   );
   sync_fifo_flex #(.DATA_W(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) dut_b (
      .clk (clk), .rst (rst_b), .bus (b_if)
   );

   typedef struct {
      logic       rst, w, r;
      logic [7:0] d;
      int         cnt;
      logic       ovf, unf, chk_rd;
      logic [7:0] rd;
   } vec_t;

   vec_t tbl[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic add(input int rs, input int w, input int d, input int r, input int cnt,
                      input int ovf, input int unf, input int chk_rd, input int rd);
      vec_t v;
      v.rst = rs[0]; v.w = w[0]; v.d = 8'(d); v.r = r[0]; v.cnt = cnt;
      v.ovf = ovf[0]; v.unf = unf[0]; v.chk_rd = chk_rd[0]; v.rd = 8'(rd);
      tbl.push_back(v);
   endtask

   task automatic stepb(input int rs, input int w, input int d, input int r);
      @(negedge clk);
      rst_b = rs[0]; b_if.w_en = w[0]; b_if.wdata = 8'(d); b_if.r_en = r[0];
      @(posedge clk);
      #1;
   endtask

   task automatic chkb(input string tag, input int cnt, input int rd, input int ovf, input int unf);
      chk({tag, " count"}, 32'(b_if.count), cnt);
      chk({tag, " empty"}, 32'(b_if.empty), (cnt == 0) ? 1 : 0);
      chk({tag, " full"}, 32'(b_if.full), (cnt == 5) ? 1 : 0);
      chk({tag, " afull"}, 32'(b_if.almost_full), (cnt >= 4) ? 1 : 0);
      chk({tag, " aempty"}, 32'(b_if.almost_empty), (cnt <= 1) ? 1 : 0);
      chk({tag, " rdata"}, 32'(b_if.rdata), rd);
      chk({tag, " ovf"}, 32'(b_if.overflow), ovf);
      chk({tag, " unf"}, 32'(b_if.underflow), unf);
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      a_if.w_en = 1'b0; a_if.wdata = '0; a_if.r_en = 1'b0;
      b_if.w_en = 1'b0; b_if.wdata = '0; b_if.r_en = 1'b0;

      // reset with both requests asserted
      add(1, 1, 8'h11, 1, 0, 0, 0, 1, 0);
      add(1, 1, 8'h22, 1, 0, 0, 0, 1, 0);
      // fill, then a rejected 17th write
      for (int i = 0; i < 16; i++) add(0, 1, i, 0, i + 1, 0, 0, 1, 0);
      add(0, 1, 8'hAA, 0, 16, 1, 0, 0, 0);
      add(0, 0, 0, 0, 16, 0, 0, 0, 0);
      // drain in order, then a rejected read
      for (int i = 0; i < 16; i++) add(0, 0, 0, 1, 15 - i, 0, 0, 1, i);
      add(0, 0, 0, 1, 0, 0, 1, 1, 8'h0F);
      add(0, 0, 0, 0, 0, 0, 0, 1, 8'h0F);
      // full plus simultaneous read/write for 20 cycles, pointers wrap
      for (int i = 0; i < 16; i++) add(0, 1, 8'h20 + i, 0, i + 1, 0, 0, 1, 8'h0F);
      for (int k = 0; k < 20; k++)
         add(0, 1, 8'h40 + k, 1, 16, 0, 0, 1, (k < 16) ? (8'h20 + k) : (8'h40 + k - 16));
      for (int j = 0; j < 16; j++) add(0, 0, 0, 1, 15 - j, 0, 0, 1, 8'h44 + j);
      // empty plus simultaneous read/write
      add(0, 1, 8'h77, 1, 1, 0, 1, 1, 8'h53);
      add(0, 0, 0, 1, 0, 0, 0, 1, 8'h77);
      // mid-operation reset at count 9
      for (int i = 0; i < 9; i++) add(0, 1, 8'h90 + i, 0, i + 1, 0, 0, 0, 0);
      add(1, 1, 8'hEE, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 1, 1, 0);
      add(0, 1, 8'h5A, 0, 1, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1, 8'h5A);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst_a = tbl[i].rst; a_if.w_en = tbl[i].w; a_if.wdata = tbl[i].d; a_if.r_en = tbl[i].r;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d count", i), 32'(a_if.count), tbl[i].cnt);
         chk($sformatf("v%0d empty", i), 32'(a_if.empty), (tbl[i].cnt == 0) ? 1 : 0);
         chk($sformatf("v%0d full", i), 32'(a_if.full), (tbl[i].cnt == 16) ? 1 : 0);
         chk($sformatf("v%0d afull", i), 32'(a_if.almost_full), (tbl[i].cnt >= 14) ? 1 : 0);
         chk($sformatf("v%0d aempty", i), 32'(a_if.almost_empty), (tbl[i].cnt <= 2) ? 1 : 0);
         chk($sformatf("v%0d ovf", i), 32'(a_if.overflow), 32'(tbl[i].ovf));
         chk($sformatf("v%0d unf", i), 32'(a_if.underflow), 32'(tbl[i].unf));
         if (tbl[i].chk_rd) chk($sformatf("v%0d rdata", i), 32'(a_if.rdata), 32'(tbl[i].rd));
      end
      @(negedge clk);
      a_if.w_en = 1'b0; a_if.r_en = 1'b0;

      // FWFT build, DEPTH 5
      stepb(1, 1, 8'h33, 1);
      stepb(1, 0, 0, 0);
      chkb("b reset", 0, 0, 0, 0);
      @(negedge clk);
      rst_b = 1'b0; b_if.w_en = 1'b1; b_if.wdata = 8'h3C; b_if.r_en = 1'b0;
      #1;
      chk("b no bypass", 32'(b_if.rdata), 0);
      @(posedge clk);
      #1;
      chkb("b first word", 1, 8'h3C, 0, 0);
      stepb(0, 0, 0, 0);
      chkb("b hold head", 1, 8'h3C, 0, 0);
      stepb(0, 0, 0, 1);
      chkb("b pop", 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         stepb(0, 1, 8'hA0 + k, 0);
         chkb($sformatf("b fill%0d", k), k + 1, 8'hA0, 0, 0);
      end
      stepb(0, 1, 8'hEE, 0);
      chkb("b overflow", 5, 8'hA0, 1, 0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("b head%0d", k), 32'(b_if.rdata), 8'hA0 + k);
         stepb(0, 0, 0, 1);
      end
      chkb("b drained", 0, 0, 0, 0);
      stepb(0, 1, 8'h5C, 1);
      chkb("b empty wr+rd", 1, 8'h5C, 0, 1);
      stepb(0, 0, 0, 1);
      chkb("b last pop", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
